// File: rtl/tx_fifo_uart.sv
// tx_fifo_uart: byte FIFO feeding an 8N1 UART transmitter (even parity bit added when TX_PARITY_EN is defined)
`timescale 1ns/1ps
module tx_fifo_uart #(
    parameter int BAUD_RATE = 9600,
    parameter int CLOCK     = 50000000,
    parameter int ADDR_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] w_data,
    input  logic       wr,
    output logic       tx_full,
    output logic       o_tx,
    output logic       tx_busy
);
    localparam int DIV_RAW = CLOCK / (BAUD_RATE * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DEPTH   = 1 << ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wp_q, rp_q;
    logic [ADDR_W:0]   cnt_q;
    logic [DW-1:0]     div_q, div_d;
    logic [3:0]        tick_q, tick_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        sh_q, sh_d;
    logic              tx_q, tx_d;
`ifdef TX_PARITY_EN
    logic              par_q, par_d;
`endif
    logic              push, pop, tick, bit_end;

    assign tx_full = cnt_q == (ADDR_W+1)'(DEPTH);
    assign push    = wr && !tx_full;
    assign pop     = (state_q == IDLE) && (cnt_q != '0);
    assign tx_busy = (state_q != IDLE) || (cnt_q != '0);
    assign tick    = div_q == DW'(DIV - 1);
    assign bit_end = tick && (tick_q == 4'd15);
    assign o_tx    = tx_q;

    // FIFO storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push) mem[wp_q] <= w_data;
    end

    // pointers, occupancy and transmitter state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            div_q   <= '0;
            tick_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
`ifdef TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            wp_q    <= wp_q + ADDR_W'(push);
            rp_q    <= rp_q + ADDR_W'(pop);
            cnt_q   <= cnt_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
            div_q   <= div_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
`ifdef TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // next state: pop on IDLE, advance one frame bit per 16 oversample ticks; line lags state by one clock
    always_comb begin
        state_d = state_q;
        div_d   = tick ? '0 : div_q + 1'b1;
        tick_d  = tick_q + 4'(tick);
        bit_d   = bit_q;
        sh_d    = sh_q;
`ifdef TX_PARITY_EN
        par_d   = par_q;
`endif
        tx_d    = (state_q == START) ? 1'b0 :
                  (state_q == DATA)  ? sh_q[0] :
`ifdef TX_PARITY_EN
                  (state_q == PARITY) ? par_q :
`endif
                  1'b1;
        if (pop) begin
            state_d = START;
            sh_d    = mem[rp_q];
            div_d   = '0;
            tick_d  = '0;
            bit_d   = '0;
`ifdef TX_PARITY_EN
            par_d   = ^mem[rp_q];
`endif
        end else if (bit_end) begin
            case (state_q)
                START:   state_d = DATA;
                DATA: begin
                    sh_d  = sh_q >> 1;
                    bit_d = bit_q + 1'b1;
`ifdef TX_PARITY_EN
                    state_d = (bit_q == 3'd7) ? PARITY : DATA;
`else
                    state_d = (bit_q == 3'd7) ? STOP : DATA;
`endif
                end
`ifdef TX_PARITY_EN
                PARITY:  state_d = STOP;
`endif
                STOP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tx_fifo_uart.sv
// tb_tx_fifo_uart: directed scoreboard bench for tx_fifo_uart (frame length follows TX_PARITY_EN)
`timescale 1ns/1ps
module tb_tx_fifo_uart;
`ifdef TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] w_data = 8'h00;
    logic       tx_full, o_tx, tx_busy;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] sb[$];

    tx_fifo_uart #(.BAUD_RATE(100000), .CLOCK(1600000), .ADDR_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .w_data(w_data), .wr(wr),
        .tx_full(tx_full), .o_tx(o_tx), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one-cycle write from a falling edge; accepted bytes go to the scoreboard
    task automatic put(input logic [7:0] b, input bit accept);
        w_data = b;
        wr = 1'b1;
        if (accept) sb.push_back(b);
        @(negedge clk);
        wr = 1'b0;
    endtask

    // wait for a start bit (exp_gap = falling edges until line low), then check every clock of the frame
    task automatic expect_frame(input string tag, input int exp_gap);
        int g;
        logic [7:0] b;
        logic [NBITS-1:0] fr;
        logic [15:0] v;
        for (g = 1; g <= 300; g++) begin
            @(negedge clk);
            if (o_tx === 1'b0) break;
        end
        chk($sformatf("%s gap", tag), g, exp_gap);
        if (g > 300) return;
        chk($sformatf("%s busy", tag), tx_busy, 1'b1);
        b = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
`ifdef TX_PARITY_EN
        fr = {1'b1, ^b, b, 1'b0};
`else
        fr = {1'b1, b, 1'b0};
`endif
        for (int k = 0; k < NBITS; k++) begin
            for (int j = 0; j < 16; j++) begin
                if (k != 0 || j != 0) @(negedge clk);
                v[j] = o_tx;
            end
            chk($sformatf("%s bit%0d", tag, k), v, {16{fr[k]}});
        end
    endtask

    initial begin
        int lows;
        repeat (3) @(negedge clk);
        chk("rst o_tx", o_tx, 1'b1);
        chk("rst full", tx_full, 1'b0);
        chk("rst busy", tx_busy, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle o_tx", o_tx, 1'b1);
        chk("idle busy", tx_busy, 1'b0);

        put(8'hA5, 1'b1);
        chk("A5 busy", tx_busy, 1'b1);
        expect_frame("fA5", 2);
        @(negedge clk);
        chk("A5 done busy", tx_busy, 1'b0);
        chk("A5 done o_tx", o_tx, 1'b1);

        fork
            expect_frame("f01", 3);
            begin
                put(8'h01, 1'b1);
                put(8'h02, 1'b1);
                put(8'h03, 1'b1);
                put(8'h04, 1'b1);
                chk("full before 5th", tx_full, 1'b0);
                put(8'h05, 1'b1);
                chk("full after 5th", tx_full, 1'b1);
                put(8'hFF, 1'b0);
                chk("full after FF", tx_full, 1'b1);
            end
        join
        expect_frame("f02", 2);
        expect_frame("f03", 2);
        expect_frame("f04", 2);
        expect_frame("f05", 2);
        @(negedge clk);
        chk("burst done busy", tx_busy, 1'b0);
        chk("burst sb left", sb.size(), 0);
        lows = 0;
        repeat (40) begin
            @(negedge clk);
            if (o_tx !== 1'b1) lows++;
        end
        chk("no FF frame", lows, 0);

        put(8'h3C, 1'b1);
        put(8'h11, 1'b1);
        put(8'h22, 1'b1);
        chk("3C start", o_tx, 1'b0);
        repeat (40) @(negedge clk);
        chk("3C data bit1", o_tx, 1'b0);
        repeat (32) @(negedge clk);
        chk("3C data bit3", o_tx, 1'b1);
        chk("3C busy", tx_busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort o_tx", o_tx, 1'b1);
        chk("abort busy", tx_busy, 1'b0);
        chk("abort full", tx_full, 1'b0);
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        lows = 0;
        repeat (60) begin
            @(negedge clk);
            if (o_tx !== 1'b1 || tx_busy !== 1'b0) lows++;
        end
        chk("quiet after reset", lows, 0);
        put(8'h5A, 1'b1);
        expect_frame("f5A", 2);
        @(negedge clk);
        chk("5A done busy", tx_busy, 1'b0);

`ifdef TX_PARITY_EN
        put(8'h07, 1'b1);
        expect_frame("p07", 2);
        put(8'h03, 1'b1);
        expect_frame("p03", 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tx_fifo_uart.md
TX_FIFO_UART -- requirements
Module: tx_fifo_uart

Interface
REQ-001 The block SHALL have parameter BAUD_RATE, default 9600, serial line rate in bit/s.
REQ-002 The block SHALL have parameter CLOCK, default 50000000, clk frequency in Hz.
REQ-003 The block SHALL have parameter ADDR_W, default 4, FIFO depth = 2^ADDR_W bytes.
REQ-004 The block SHALL have port clk, input, 1 bit: single system clock, all state on rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port w_data, input, 8 bits: byte to enqueue.
REQ-007 The block SHALL have port wr, input, 1 bit: write strobe, one byte per high cycle.
REQ-008 The block SHALL have port tx_full, output, 1 bit: FIFO holds 2^ADDR_W bytes.
REQ-009 The block SHALL have port o_tx, output, 1 bit: serial line, idle high, registered.
REQ-010 The block SHALL have port tx_busy, output, 1 bit: frame in progress or FIFO non-empty.

Function
REQ-011 The block SHALL derive DIV = CLOCK/(BAUD_RATE*16) by integer division, with a minimum of 1; one oversample tick = DIV clocks; one bit period = 16 ticks = 16*DIV clocks.
REQ-012 The block SHALL accept a write in any cycle with wr=1 and tx_full=0, storing w_data at the write pointer (mod 2^ADDR_W) and incrementing the count.
REQ-013 The block SHALL ignore wr=1 while tx_full=1: no storage, no pointer or count change, no error flag.
REQ-014 On simultaneous accepted write and pop, the block SHALL advance both pointers and leave the count unchanged.
REQ-015 The block SHALL maintain a count of width ADDR_W+1; tx_full = (count == 2^ADDR_W); the FIFO is empty when count == 0; pointers wrap modulo 2^ADDR_W.
REQ-016 The transmitter FSM SHALL have states IDLE, START, DATA, STOP, plus PARITY when TX_PARITY_EN is defined.
REQ-017 IDLE: o_tx=1; if the FIFO is non-empty, the block SHALL pop the head byte into the shift register, clear the tick divider, bit-tick and bit counters, and go to START at the same edge.
REQ-018 Latency: a byte written into an empty FIFO with the FSM in IDLE SHALL be popped at the next edge, with o_tx low from the edge after that.
REQ-019 START SHALL drive o_tx=0 for one bit period, then go to DATA.
REQ-020 DATA SHALL send 8 bits LSB first, each for one bit period, then go to STOP (or PARITY).
REQ-021 STOP SHALL drive o_tx=1 for one bit period, then go to IDLE.
REQ-022 Back-to-back frames SHALL be sent with exactly one idle clock between STOP end and the next START.
REQ-023 tx_busy SHALL be high when FSM != IDLE or the FIFO is non-empty.

Reset
REQ-024 While rst_n=0, the block SHALL hold o_tx=1, tx_full=0, tx_busy=0, FSM=IDLE, and pointers, count, all counters and the shift register at 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately (o_tx=1 asynchronously) and discard FIFO contents.
REQ-026 After release, the block SHALL start no frame before the first rising edge with rst_n=1 and a write.

Configuration
REQ-027 Macro TX_PARITY_EN defined: the block SHALL add state PARITY after DATA, sending one bit of even parity (XOR of the 8 data bits) for one bit period, frame = 11 bits.
REQ-028 Macro TX_PARITY_EN undefined: the block SHALL have no PARITY state or logic, frame = 10 bits (8N1).

Verification
REQ-029 Bench parameters: CLOCK=1600000, BAUD_RATE=100000 (DIV=1, bit=16 clocks), ADDR_W=2.
REQ-030 Write 0xA5 once -> o_tx low 2 edges after write edge; 16 clocks per bit; line 0,1,0,1,0,0,1,0,1,1 (start, LSB first, stop); tx_busy falls after stop.
REQ-031 Write 0x01,0x02,0x03,0x04,0x05 on consecutive cycles -> 0x01 popped immediately, 0x02-0x05 fill FIFO, tx_full=1 after the 0x05 write edge, all five serialized in order, one idle clock between frames.
REQ-032 With tx_full=1, pulse wr with 0xFF -> ignored, count stays 4, 0xFF never transmitted.
REQ-033 Assert rst_n=0 during DATA bit 3 of 0x3C with 2 bytes queued -> o_tx=1 at once, tx_busy=0, tx_full=0; after release no output until a new write.
REQ-034 With TX_PARITY_EN, write 0x07 -> parity bit 1, frame 0,1,1,1,0,0,0,0,0,1,1 (11 bits); write 0x03 -> parity bit 0.
